// File: rtl/boot_fetch_router_pkg.sv
// Shared fetch-path definitions: memory map defaults, fetch targets and router states.
package boot_fetch_router_pkg;

    localparam logic [31:0] BOOT_BASE_DEF  = 32'h0000_1000;
    localparam int unsigned BOOT_BYTES_DEF = 8192;
    localparam logic [31:0] DRAM_BASE_DEF  = 32'h8000_0000;

    typedef enum logic [1:0] {
        FT_ROM,
        FT_IC,
        FT_FLT
    } fetch_tgt_e;

    typedef enum logic [1:0] {
        FR_BOOT,
        FR_RUN,
        FR_DRAIN
    } fetch_router_state_e;

endpackage

// File: rtl/boot_fetch_router_addr_decode.sv
// Combinational fetch address decoder: boot ROM window, DRAM/icache region, or fault.
module fetch_addr_decode
    import boot_fetch_router_pkg::*;
#(
    parameter logic [31:0] BOOT_BASE  = BOOT_BASE_DEF,
    parameter int unsigned BOOT_BYTES = BOOT_BYTES_DEF,
    parameter logic [31:0] DRAM_BASE  = DRAM_BASE_DEF
) (
    input  logic [31:0] addr,
    output fetch_tgt_e  tgt
);

    localparam logic [31:0] ROM_SIZE = 32'(BOOT_BYTES);

    logic [31:0] rom_off;

    // Unsigned wrap makes addresses below BOOT_BASE land far outside the window.
    assign rom_off = addr - BOOT_BASE;

    always_comb begin
        tgt = FT_FLT;
        if (rom_off < ROM_SIZE) begin
            tgt = FT_ROM;
        end else if (addr >= DRAM_BASE) begin
            tgt = FT_IC;
        end
    end

endmodule

// File: rtl/boot_fetch_router.sv
// Fetch router between IF, boot ROM and icache: in-order responses, boot phase, flush drain.
module boot_fetch_router
    import boot_fetch_router_pkg::*;
#(
    parameter logic [31:0] BOOT_BASE       = BOOT_BASE_DEF,
    parameter int unsigned BOOT_BYTES      = BOOT_BYTES_DEF,
    parameter logic [31:0] DRAM_BASE       = DRAM_BASE_DEF,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic        res_fault,
    output logic        rom_req_valid,
    output logic [31:0] rom_req_addr,
    input  logic        rom_res_valid,
    input  logic [31:0] rom_res_data,
    output logic        ic_req_valid,
    input  logic        ic_req_ready,
    output logic [31:0] ic_req_addr,
    input  logic        ic_res_valid,
    input  logic [31:0] ic_res_data,
    output logic        boot_done
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    fetch_router_state_e state_q, state_d;
    fetch_tgt_e          cur_tgt_q, cur_tgt_d;
    fetch_tgt_e          tgt;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    kill_q, kill_d;
    logic                boot_done_q, boot_done_d;
    logic                flt_q, flt_d;
    logic                issue_ok, accept, rsp, retire;

    fetch_addr_decode #(
        .BOOT_BASE (BOOT_BASE),
        .BOOT_BYTES(BOOT_BYTES),
        .DRAM_BASE (DRAM_BASE)
    ) u_decode (
        .addr(req_addr),
        .tgt (tgt)
    );

    assign rom_req_addr = req_addr;
    assign ic_req_addr  = req_addr;
    assign boot_done    = boot_done_q;

    // Handshake and response mux; everything is gated off while reset is held low.
    always_comb begin
        issue_ok = (state_q != FR_DRAIN) && !flush && (cnt_q < MAX_CNT)
                   && ((cnt_q == '0) || (tgt == cur_tgt_q));
        req_ready     = reset && issue_ok && ((tgt != FT_IC) || ic_req_ready);
        rom_req_valid = reset && req_valid && issue_ok && (tgt == FT_ROM);
        ic_req_valid  = reset && req_valid && issue_ok && (tgt == FT_IC);
        accept        = req_valid && req_ready;

        case (cur_tgt_q)
            FT_ROM:  rsp = rom_res_valid;
            FT_IC:   rsp = ic_res_valid;
            default: rsp = flt_q;
        endcase
        retire = rsp && (cnt_q != '0);

        res_valid = reset && retire && !flush && (state_q != FR_DRAIN);
        res_fault = res_valid && (cur_tgt_q == FT_FLT);
        res_data  = 32'h0;
        if (res_valid && (cur_tgt_q == FT_ROM)) begin
            res_data = rom_res_data;
        end else if (res_valid && (cur_tgt_q == FT_IC)) begin
            res_data = ic_res_data;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept && !retire) begin
            cnt_d = cnt_q + ONE;
        end else if (!accept && retire) begin
            cnt_d = cnt_q - ONE;
        end
        cur_tgt_d   = accept ? tgt : cur_tgt_q;
        flt_d       = accept && (tgt == FT_FLT);
        kill_d      = kill_q;
        state_d     = state_q;
        boot_done_d = boot_done_q;

        case (state_q)
            FR_BOOT, FR_RUN: begin
                // flush blocks accept, so cnt_d is already net of any same-cycle retire
                if (flush) begin
                    kill_d = cnt_d;
                    if (cnt_d != '0) begin
                        state_d = FR_DRAIN;
                    end
                end else if (accept && (tgt == FT_IC)) begin
                    boot_done_d = 1'b1;
                    state_d     = FR_RUN;
                end
            end
            FR_DRAIN: begin
                if (retire) begin
                    kill_d = kill_q - ONE;
                    if (kill_d == '0) begin
                        state_d = boot_done_q ? FR_RUN : FR_BOOT;
                    end
                end
            end
            default: state_d = FR_BOOT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= FR_BOOT;
            cnt_q       <= '0;
            kill_q      <= '0;
            cur_tgt_q   <= FT_ROM;
            boot_done_q <= 1'b0;
            flt_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            kill_q      <= kill_d;
            cur_tgt_q   <= cur_tgt_d;
            boot_done_q <= boot_done_d;
            flt_q       <= flt_d;
        end
    end

    // A downstream response with nothing in flight must come from the last-used target.
    assert property (@(posedge clock) disable iff (!reset)
        (cnt_q == '0) |-> !((rom_res_valid && (cur_tgt_q != FT_ROM))
                            || (ic_res_valid && (cur_tgt_q != FT_IC))));

endmodule

// File: tb/tb_boot_fetch_router.sv
// Directed bench for boot_fetch_router with a 1-cycle ROM model and a hand-driven icache.
module tb_boot_fetch_router;

    logic        clock = 1'b0;
    logic        reset, flush, req_valid, req_ready;
    logic [31:0] req_addr;
    logic        res_valid, res_fault;
    logic [31:0] res_data;
    logic        rom_req_valid, rom_res_valid;
    logic [31:0] rom_req_addr, rom_res_data;
    logic        ic_req_valid, ic_req_ready, ic_res_valid;
    logic [31:0] ic_req_addr, ic_res_data;
    logic        boot_done;
    int          checks = 0;
    int          errors = 0;

    boot_fetch_router dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .res_fault    (res_fault),
        .rom_req_valid(rom_req_valid),
        .rom_req_addr (rom_req_addr),
        .rom_res_valid(rom_res_valid),
        .rom_res_data (rom_res_data),
        .ic_req_valid (ic_req_valid),
        .ic_req_ready (ic_req_ready),
        .ic_req_addr  (ic_req_addr),
        .ic_res_valid (ic_res_valid),
        .ic_res_data  (ic_res_data),
        .boot_done    (boot_done)
    );

    always #5 clock = ~clock;

    // ROM returns {16'hA500, addr[15:0]} one cycle after the strobe.
    always @(posedge clock) begin
        if (!reset) begin
            rom_res_valid <= 1'b0;
            rom_res_data  <= 32'h0;
        end else begin
            rom_res_valid <= rom_req_valid;
            rom_res_data  <= rom_req_valid ? {16'hA500, rom_req_addr[15:0]} : 32'h0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; req_valid = 1'b0; req_addr = 32'h0;
        ic_req_ready = 1'b0; ic_res_valid = 1'b0; ic_res_data = 32'h0;
        tick(); tick();
        req_valid = 1'b1; req_addr = 32'h0000_1000;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rom_valid", 32'(rom_req_valid), 32'h0);
        chk("rst_res_valid", 32'(res_valid), 32'h0);
        chk("rst_boot_done", 32'(boot_done), 32'h0);
        tick();

        // first ROM fetch after reset release
        reset = 1'b1;
        #1;
        chk("t1_req_ready", 32'(req_ready), 32'h1);
        chk("t1_rom_valid", 32'(rom_req_valid), 32'h1);
        chk("t1_rom_addr", rom_req_addr, 32'h0000_1000);
        chk("t1_ic_valid", 32'(ic_req_valid), 32'h0);
        tick();
        req_valid = 1'b0;
        #1;
        chk("t1_res_valid", 32'(res_valid), 32'h1);
        chk("t1_res_data", res_data, 32'hA500_1000);
        chk("t1_res_fault", 32'(res_fault), 32'h0);
        chk("t1_boot_done", 32'(boot_done), 32'h0);
        tick();
        chk("t1_idle", 32'(res_valid), 32'h0);

        // five back-to-back ROM fetches, in-order data
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_addr = 32'h0000_1000 + 32'(4 * i);
            #1;
            chk("t2_ready", 32'(req_ready), 32'h1);
            if (i > 0) begin
                chk("t2_res_valid", 32'(res_valid), 32'h1);
                chk("t2_res_data", res_data, 32'hA500_1000 + 32'(4 * (i - 1)));
            end
            tick();
        end
        req_valid = 1'b0;
        #1;
        chk("t2_last_data", res_data, 32'hA500_1010);
        tick();

        // ROM then icache: target switch waits for the ROM response
        ic_req_ready = 1'b1;
        req_valid = 1'b1; req_addr = 32'h0000_1FFC;
        #1;
        chk("t3_rom_ready", 32'(req_ready), 32'h1);
        tick();
        req_addr = 32'h8000_0000;
        #1;
        chk("t3_ic_held", 32'(req_ready), 32'h0);
        chk("t3_ic_valid_held", 32'(ic_req_valid), 32'h0);
        chk("t3_rom_res", res_data, 32'hA500_1FFC);
        tick();
        chk("t3_ic_ready", 32'(req_ready), 32'h1);
        chk("t3_ic_valid", 32'(ic_req_valid), 32'h1);
        chk("t3_ic_addr", ic_req_addr, 32'h8000_0000);
        chk("t3_boot_pre", 32'(boot_done), 32'h0);
        tick();
        req_valid = 1'b0;
        #1;
        chk("t3_boot_done", 32'(boot_done), 32'h1);
        chk("t3_lat1", 32'(res_valid), 32'h0);
        tick();
        chk("t3_lat2", 32'(res_valid), 32'h0);
        tick();
        ic_res_valid = 1'b1; ic_res_data = 32'hDEAD_0001;
        #1;
        chk("t3_ic_res_valid", 32'(res_valid), 32'h1);
        chk("t3_ic_res_data", res_data, 32'hDEAD_0001);
        tick();
        ic_res_valid = 1'b0;
        #1;
        chk("t3_ic_idle", 32'(res_valid), 32'h0);

        // fault region
        req_valid = 1'b1; req_addr = 32'h4000_0000;
        #1;
        chk("t4_ready", 32'(req_ready), 32'h1);
        chk("t4_no_rom", 32'(rom_req_valid), 32'h0);
        chk("t4_no_ic", 32'(ic_req_valid), 32'h0);
        tick();
        req_valid = 1'b0;
        #1;
        chk("t4_res_valid", 32'(res_valid), 32'h1);
        chk("t4_res_fault", 32'(res_fault), 32'h1);
        chk("t4_res_data", res_data, 32'h0);
        tick();
        chk("t4_idle", 32'(res_valid), 32'h0);

        // decode boundaries, probed without accepting
        req_valid = 1'b1; req_addr = 32'h0000_2FFC;
        #1; chk("dec_rom_top", 32'(rom_req_valid), 32'h1);
        req_addr = 32'h0000_3000;
        #1; chk("dec_rom_end", 32'(rom_req_valid), 32'h0);
        req_addr = 32'h0000_0FFC;
        #1; chk("dec_below", 32'(rom_req_valid), 32'h0);
        req_addr = 32'h7FFF_FFFC;
        #1; chk("dec_below_dram", 32'(ic_req_valid), 32'h0);
        req_valid = 1'b0;
        tick();

        // icache backpressure
        req_valid = 1'b1; req_addr = 32'h8000_0000; ic_req_ready = 1'b0;
        #1;
        chk("bp_ready", 32'(req_ready), 32'h0);
        chk("bp_valid", 32'(ic_req_valid), 32'h1);
        req_valid = 1'b0; ic_req_ready = 1'b1;
        tick();

        // fill to MAX_OUTSTANDING, no same-cycle bypass of a retire
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_addr = 32'h8000_0010 + 32'(4 * i);
            #1;
            chk("t5_fill_ready", 32'(req_ready), 32'h1);
            tick();
        end
        req_addr = 32'h8000_0020;
        #1;
        chk("t5_full_ready", 32'(req_ready), 32'h0);
        chk("t5_full_icv", 32'(ic_req_valid), 32'h0);
        ic_res_valid = 1'b1; ic_res_data = 32'hC0DE_0000;
        #1;
        chk("t5_nobypass", 32'(req_ready), 32'h0);
        chk("t5_res0", res_data, 32'hC0DE_0000);
        tick();
        ic_res_valid = 1'b0;
        #1;
        chk("t5_reopen", 32'(req_ready), 32'h1);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ic_res_valid = 1'b1; ic_res_data = 32'hC0DE_0001 + 32'(i);
            #1;
            chk("t5_drain_valid", 32'(res_valid), 32'h1);
            chk("t5_drain_data", res_data, 32'hC0DE_0001 + 32'(i));
            tick();
        end
        ic_res_valid = 1'b0;

        // flush with three in flight and one response in the flush cycle
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_addr = 32'h8000_0040 + 32'(4 * i);
            tick();
        end
        req_addr = 32'h8000_0100;
        flush = 1'b1; ic_res_valid = 1'b1; ic_res_data = 32'hBAD0_0000;
        #1;
        chk("t6_flush_res", 32'(res_valid), 32'h0);
        chk("t6_flush_ready", 32'(req_ready), 32'h0);
        chk("t6_flush_icv", 32'(ic_req_valid), 32'h0);
        tick();
        flush = 1'b0; ic_res_valid = 1'b0;
        #1;
        chk("t6_drain_ready", 32'(req_ready), 32'h0);
        ic_res_valid = 1'b1; ic_res_data = 32'hBAD0_0001;
        #1;
        chk("t6_drop1", 32'(res_valid), 32'h0);
        tick();
        ic_res_data = 32'hBAD0_0002;
        #1;
        chk("t6_drop2", 32'(res_valid), 32'h0);
        chk("t6_drain_ready2", 32'(req_ready), 32'h0);
        tick();
        ic_res_valid = 1'b0;
        #1;
        chk("t6_run_ready", 32'(req_ready), 32'h1);
        chk("t6_run_boot", 32'(boot_done), 32'h1);
        req_valid = 1'b0;
        tick();

        // reset with two icache fetches in flight
        for (int i = 0; i < 2; i++) begin
            req_valid = 1'b1; req_addr = 32'h8000_0200 + 32'(4 * i);
            tick();
        end
        req_valid = 1'b0; reset = 1'b0; ic_res_valid = 1'b1; ic_res_data = 32'h1234_5678;
        #1;
        chk("t7_rst_res", 32'(res_valid), 32'h0);
        tick();
        reset = 1'b1; ic_res_valid = 1'b0;
        #1;
        chk("t7_boot_done", 32'(boot_done), 32'h0);
        chk("t7_res_valid", 32'(res_valid), 32'h0);
        req_valid = 1'b1; req_addr = 32'h0000_1000;
        #1;
        chk("t7_rom_ready", 32'(req_ready), 32'h1);
        chk("t7_rom_valid", 32'(rom_req_valid), 32'h1);
        tick();
        req_valid = 1'b0;
        #1;
        chk("t7_rom_data", res_data, 32'hA500_1000);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
